// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Opcodes, FSM state encoding and lane-count helper.
package lsu_pkg;

  localparam logic [4:0] OP_LW = 5'b00000;
  localparam logic [4:0] OP_SW = 5'b00001;
  localparam logic [4:0] OP_LB = 5'b00010;
  localparam logic [4:0] OP_SB = 5'b00011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  function automatic int lsu_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/lsu_lane_sel.sv
// Byte-lane extract / sign-extend and byte-enable generator.
// Purely combinational.
module lsu_lane_sel
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0]            rdata,
  input  logic [$clog2(DWIDTH/8)-1:0]  off,
  input  logic                         is_byte,
  output logic [DWIDTH/8-1:0]          be,
  output logic [DWIDTH-1:0]            ldata
);

  localparam int LANES = lsu_lanes(DWIDTH);
  localparam int OB    = $clog2(LANES);

  logic [7:0] lane;

  always_comb begin
    lane = 8'h00;
    for (int i = 0; i < LANES; i++) begin
      if (off == OB'(i))
        lane = rdata[i*8 +: 8];
    end
  end

  always_comb begin
    be    = '1;
    ldata = rdata;
    if (is_byte) begin
      be    = LANES'(1) << off;
      ldata = {{(DWIDTH-8){lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-access load/store unit: IDLE -> REQ -> RESP handshake
// with a bounded wait on mem_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AWIDTH  = 15,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DWIDTH-1:0]     instr,
  input  logic [DWIDTH-1:0]     data_ula,
  input  logic [DWIDTH-1:0]     register_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DWIDTH-1:0]     load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH/8-1:0]   mem_be,
  output logic [DWIDTH-1:0]     mem_wdata,
  input  logic                  mem_ready,
  input  logic [DWIDTH-1:0]     mem_rdata
);

  localparam int LANES = lsu_lanes(DWIDTH);
  localparam int OB    = $clog2(LANES);

  lsu_state_t state, state_nx;

  logic [OB-1:0]     off_q;
  logic              byte_q;
  logic              err_q;
  logic [15:0]       cnt_q;

  logic [4:0]        op_in;
  logic [OB-1:0]     off_in;
  logic              is_word;
  logic              is_byte;
  logic              is_store;
  logic              legal;
  logic              tmo_hit;

  logic [OB-1:0]     sel_off;
  logic              sel_byte;
  logic [LANES-1:0]  sel_be;
  logic [DWIDTH-1:0] sel_ldata;

  logic              unused;

  assign op_in  = instr[DWIDTH-1:DWIDTH-5];
  assign off_in = data_ula[OB-1:0];

  always_comb begin
    is_word  = 1'b0;
    is_byte  = 1'b0;
    is_store = 1'b0;
    unique case (op_in)
      OP_LW: is_word = 1'b1;
      OP_SW: begin
        is_word  = 1'b1;
        is_store = 1'b1;
      end
      OP_LB: is_byte = 1'b1;
      OP_SB: begin
        is_byte  = 1'b1;
        is_store = 1'b1;
      end
      default: ;
    endcase
  end

  assign legal   = is_byte | (is_word & (off_in == '0));
  assign tmo_hit = (cnt_q == 16'(TIMEOUT - 1));

  // Byte-enables come from the live inputs at start; the
  // load lane comes from the captured offset during REQ.
  assign sel_off  = (state == S_IDLE) ? off_in  : off_q;
  assign sel_byte = (state == S_IDLE) ? is_byte : byte_q;

  lsu_lane_sel #(
    .DWIDTH (DWIDTH)
  ) u_lane_sel (
    .rdata   (mem_rdata),
    .off     (sel_off),
    .is_byte (sel_byte),
    .be      (sel_be),
    .ldata   (sel_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_nx = legal ? S_REQ : S_RESP;
      end
      S_REQ: begin
        if (mem_ready || tmo_hit)
          state_nx = S_RESP;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    mem_req = (state == S_REQ);
    done    = (state == S_RESP);
    error   = done & err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q     <= '0;
      byte_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      load_data <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            err_q <= ~legal;
            if (legal) begin
              off_q    <= off_in;
              byte_q   <= is_byte;
              mem_we   <= is_store;
              mem_addr <= data_ula[AWIDTH+OB-1:OB];
              mem_be   <= sel_be;
              mem_wdata <= is_byte ?
                {LANES{register_data[7:0]}} :
                register_data;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            if (!mem_we)
              load_data <= sel_ldata;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign unused = ^{instr[DWIDTH-6:0],
                    data_ula[DWIDTH-1:AWIDTH+OB]};

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 15, memory word-address width.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; a power of two and at least 16.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for mem_ready; range 1..65535.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, request to begin one access; sampled only in IDLE.
REQ-007 SHALL have port instr, input, DWIDTH, instruction; opcode = instr[DWIDTH-1:DWIDTH-5].
REQ-008 SHALL have port data_ula, input, DWIDTH, ALU-computed byte address.
REQ-009 SHALL have port register_data, input, DWIDTH, store source data.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port error, output, 1, qualifies done: access was aborted.
REQ-013 SHALL have port load_data, output, DWIDTH, registered load result.
REQ-014 SHALL have port mem_req, output, 1, memory request.
REQ-015 SHALL have port mem_we, output, 1, write qualifier for mem_req.
REQ-016 SHALL have port mem_addr, output, AWIDTH, word address = data_ula[AWIDTH+OB-1:OB], where OB = log2(DWIDTH/8).
REQ-017 SHALL have port mem_be, output, DWIDTH/8, byte enables.
REQ-018 SHALL have port mem_wdata, output, DWIDTH, write data.
REQ-019 SHALL have port mem_ready, input, 1, memory accepts or completes the access in the current cycle.
REQ-020 SHALL have port mem_rdata, input, DWIDTH, read data, valid when mem_ready is high and mem_we is low.

Function
REQ-021 SHALL decode the opcode as follows: 5'b00000 LW, 5'b00001 SW, 5'b00010 LB, 5'b00011 SB; all other opcodes are illegal.
REQ-022 SHALL implement states IDLE, REQ, RESP: IDLE->REQ on start; REQ->RESP on mem_ready or timeout; RESP->IDLE unconditionally.
REQ-023 SHALL, on start in IDLE, register opcode, address and store data; no input is looked at again until the next IDLE.
REQ-024 SHALL, on an illegal opcode or a word access with address[OB-1:0] != 0, go IDLE->RESP, never assert mem_req, and pulse done with error=1.
REQ-025 SHALL hold mem_req=1 and all mem_* outputs stable throughout REQ; mem_req is 0 in every other state.
REQ-026 SHALL drive mem_be for word ops as all ones and for byte ops as one-hot at bit address[OB-1:0].
REQ-027 SHALL drive mem_wdata for SW as register_data and for SB as register_data[7:0] replicated to every lane.
REQ-028 SHALL capture mem_rdata in the REQ cycle where mem_ready=1: LW stores the full word; LB stores the selected lane, sign-extended to DWIDTH.
REQ-029 SHALL pulse done for exactly one cycle, in RESP; load_data is valid at that pulse and holds until the next load completes.
REQ-030 SHALL have latency, with mem_ready already high, of start at edge N, mem_req during cycle N+1 and done during cycle N+2.
REQ-031 SHALL count REQ cycles; if mem_ready has not been seen after TIMEOUT cycles, go to RESP with error=1 and leave load_data unchanged.
REQ-032 SHALL ignore start while busy, with no queueing.
REQ-033 SHALL allow start to be accepted in the IDLE cycle directly following RESP, giving back-to-back accesses.

Reset
REQ-034 SHALL, on rst_n low, immediately force IDLE, clear the timeout counter and zero busy, done, error, load_data, mem_req, mem_we, mem_addr, mem_be and mem_wdata.
REQ-035 SHALL abandon an access interrupted by reset mid-REQ without a done pulse.
REQ-036 SHALL release reset synchronously to clk at the system level.

Structure
REQ-037 SHALL place opcode localparams, the state encoding and a lane-count function in shared package lsu_pkg.
REQ-038 SHALL use one sub-module, lsu_lane_sel: a combinational byte-lane extract, sign-extend and byte-enable generator.

Verification
REQ-039 SHALL test LW: opcode 00000, data_ula=0x8, mem_ready tied high, mem_rdata=0xDEADBEEF -> mem_addr=2, mem_be=4'hF, done at N+2, load_data=0xDEADBEEF, error=0.
REQ-040 SHALL test SB: opcode 00011, data_ula=0x6, register_data=0x000000A5 -> mem_we=1, mem_be=4'b0100, mem_wdata=0xA5A5A5A5.
REQ-041 SHALL test LB with wait states: data_ula=0x3, mem_ready low for 3 cycles, mem_rdata=0x80000000 -> mem_req held 4 cycles, load_data=0xFFFFFF80.
REQ-042 SHALL test errors: opcode 00111 or LW at data_ula=0x2 -> no mem_req, done=1 and error=1 at N+1.
REQ-043 SHALL test timeout: TIMEOUT=4, mem_ready stuck low -> mem_req high for 4 cycles, then done=1 and error=1.
REQ-044 SHALL test reset: rst_n low during REQ -> mem_req=0 and busy=0 asynchronously, no done; start after release completes normally.
